// File: rtl/ofm_pkt_fifo_if.sv
// ofm_pkt_fifo_if - write/read bus of the MM2S store-and-forward packet FIFO.
// master: the packet producer and consumer; slave: the FIFO itself.
interface ofm_pkt_fifo_if #(
   parameter int DWIDTH = 64,
   parameter int CWIDTH = 64
);
   localparam int W = DWIDTH + DWIDTH/8 + 1;

   // write side
   logic [W-1:0]      data_fifo_wdata;
   logic              data_fifo_wren;
   logic              data_fifo_wabort;
   logic              data_fifo_afull;
   logic              data_fifo_full;
   logic [CWIDTH-1:0] ctrl_fifo_wdata;
   logic              ctrl_fifo_wren;
   logic              ctrl_fifo_afull;
   // read side
   logic [W-1:0]      data_fifo_rdata;
   logic              data_fifo_empty;
   logic              data_fifo_rden;
   logic [CWIDTH-1:0] ctrl_fifo_rdata;
   logic              ctrl_fifo_empty;
   logic              ctrl_fifo_rden;

   modport master (
      output data_fifo_wdata, data_fifo_wren, data_fifo_wabort,
      output ctrl_fifo_wdata, ctrl_fifo_wren,
      output data_fifo_rden, ctrl_fifo_rden,
      input  data_fifo_afull, data_fifo_full, ctrl_fifo_afull,
      input  data_fifo_rdata, data_fifo_empty, ctrl_fifo_rdata, ctrl_fifo_empty
   );

   modport slave (
      input  data_fifo_wdata, data_fifo_wren, data_fifo_wabort,
      input  ctrl_fifo_wdata, ctrl_fifo_wren,
      input  data_fifo_rden, ctrl_fifo_rden,
      output data_fifo_afull, data_fifo_full, ctrl_fifo_afull,
      output data_fifo_rdata, data_fifo_empty, ctrl_fifo_rdata, ctrl_fifo_empty
   );
endinterface

// File: rtl/ofm_pkt_fifo.sv
// ofm_pkt_fifo - single-clock store-and-forward packet FIFO (MM2S transmit path).
// Beats are written speculatively at wr_spec and published by moving wr_commit
// when the packet's control word arrives; an abort rewinds wr_spec to wr_commit.
// Both read ports are first-word-fall-through: the synchronous RAM read register
// doubles as the output register, so a commit is visible one edge later.
// Optional macro OFM_PKT_FIFO_STATS_EN adds the pkt_cnt / drop_cnt counters.
module ofm_pkt_fifo #(
   parameter int DWIDTH       = 64,
   parameter int CWIDTH       = 64,
   parameter int DDEPTH_LOG2  = 9,
   parameter int CDEPTH_LOG2  = 4,
   parameter int AFULL_THRESH = (1 << DDEPTH_LOG2) - 16
) (
   input  logic          mm2s_clk,
   input  logic          mm2s_resetn,
   ofm_pkt_fifo_if.slave bus
`ifdef OFM_PKT_FIFO_STATS_EN
   ,
   output logic [31:0]   pkt_cnt,
   output logic [31:0]   drop_cnt
`endif
);

   localparam int W      = DWIDTH + DWIDTH/8 + 1;
   localparam int DDEPTH = 1 << DDEPTH_LOG2;
   localparam int CDEPTH = 1 << CDEPTH_LOG2;

   // one extra MSB distinguishes full from empty when the address bits match
   typedef logic [DDEPTH_LOG2:0] dptr_t;
   typedef logic [CDEPTH_LOG2:0] cptr_t;

   logic [W-1:0]      dmem [DDEPTH];
   logic [CWIDTH-1:0] cmem [CDEPTH];

   // rd / cr count consumed words, so occupancy includes the word held in the
   // output register; dfetch / cfetch are the RAM prefetch addresses.
   dptr_t wr_spec, wr_commit, rd, dfetch;
   cptr_t cw, cr, cfetch;
   logic  bad;

   logic              dvalid, cvalid;
   logic [W-1:0]      drdata;
   logic [CWIDTH-1:0] crdata;
   logic              dfull_q, dafull_q, cafull_q;

   logic  wr_fire, bad_hit, ctrl_full, do_abort, commit_ok;
   logic  d_pop, c_pop, d_load, c_load;
   dptr_t wr_spec_nxt, wr_commit_nxt, rd_nxt, docc_nxt;
   cptr_t cw_nxt, cr_nxt, cocc, cocc_nxt;

   // Write/commit/abort decisions and next pointer values.
   always_comb begin
      // NOTE: every signal gets a value before any branch, so no latch is inferred.
      wr_fire       = bus.data_fifo_wren && !dfull_q;
      bad_hit       = bus.data_fifo_wren && dfull_q;
      cocc          = cw - cr;
      ctrl_full     = (cocc == cptr_t'(CDEPTH));
      do_abort      = bus.data_fifo_wabort ||
                      (bus.ctrl_fifo_wren && (bad || bad_hit || ctrl_full));
      commit_ok     = bus.ctrl_fifo_wren && !do_abort;
      d_pop         = bus.data_fifo_rden && dvalid;
      c_pop         = bus.ctrl_fifo_rden && cvalid;
      d_load        = (dfetch != wr_commit) && (!dvalid || d_pop);
      c_load        = (cfetch != cw) && (!cvalid || c_pop);
      wr_spec_nxt   = wr_spec + dptr_t'(wr_fire);
      wr_commit_nxt = wr_commit;
      if (do_abort) begin
         wr_spec_nxt = wr_commit;
      end else if (commit_ok) begin
         wr_commit_nxt = wr_spec_nxt;
      end
      rd_nxt   = rd + dptr_t'(d_pop);
      cw_nxt   = cw + cptr_t'(commit_ok);
      cr_nxt   = cr + cptr_t'(c_pop);
      docc_nxt = wr_spec_nxt - rd_nxt;
      cocc_nxt = cw_nxt - cr_nxt;
   end

   // Store beats and control words.
   // NOTE: the RAM arrays carry no reset; pointers alone define which entries are live.
   always_ff @(posedge mm2s_clk) begin
      if (wr_fire) dmem[wr_spec[DDEPTH_LOG2-1:0]] <= bus.data_fifo_wdata;
      if (commit_ok) cmem[cw[CDEPTH_LOG2-1:0]] <= bus.ctrl_fifo_wdata;
   end

   // Pointer, bad-flag and registered level-flag state.
   always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
      if (!mm2s_resetn) begin
         wr_spec   <= '0;
         wr_commit <= '0;
         rd        <= '0;
         cw        <= '0;
         cr        <= '0;
         bad       <= 1'b0;
         dfull_q   <= 1'b0;
         dafull_q  <= 1'b0;
         cafull_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         wr_spec   <= wr_spec_nxt;
         wr_commit <= wr_commit_nxt;
         rd        <= rd_nxt;
         cw        <= cw_nxt;
         cr        <= cr_nxt;
         bad       <= do_abort ? 1'b0 : (bad | bad_hit);
         dfull_q   <= (docc_nxt == dptr_t'(DDEPTH));
         dafull_q  <= (32'(docc_nxt) >= 32'($unsigned(AFULL_THRESH)));
         cafull_q  <= (cocc_nxt >= cptr_t'(CDEPTH - 2));
      end
   end

   // Data FWFT stage: refill the output register whenever it is free or being consumed.
   always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
      if (!mm2s_resetn) begin
         dfetch <= '0;
         dvalid <= 1'b0;
         drdata <= '0;
      end else if (d_load) begin
         drdata <= dmem[dfetch[DDEPTH_LOG2-1:0]];
         dfetch <= dfetch + dptr_t'(1);
         dvalid <= 1'b1;
      end else if (d_pop) begin
         dvalid <= 1'b0;
      end
   end

   // Control FWFT stage, same scheme as the data side.
   always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
      if (!mm2s_resetn) begin
         cfetch <= '0;
         cvalid <= 1'b0;
         crdata <= '0;
      end else if (c_load) begin
         crdata <= cmem[cfetch[CDEPTH_LOG2-1:0]];
         cfetch <= cfetch + cptr_t'(1);
         cvalid <= 1'b1;
      end else if (c_pop) begin
         cvalid <= 1'b0;
      end
   end

`ifdef OFM_PKT_FIFO_STATS_EN
   // Free-running packet statistics; a converted commit counts only as a drop.
   always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
      if (!mm2s_resetn) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (commit_ok) pkt_cnt <= pkt_cnt + 32'd1;
         if (do_abort) drop_cnt <= drop_cnt + 32'd1;
      end
   end
`endif

   assign bus.data_fifo_rdata = drdata;
   assign bus.data_fifo_empty = !dvalid;
   assign bus.ctrl_fifo_rdata = crdata;
   assign bus.ctrl_fifo_empty = !cvalid;
   assign bus.data_fifo_full  = dfull_q;
   assign bus.data_fifo_afull = dafull_q;
   assign bus.ctrl_fifo_afull = cafull_q;

endmodule

// File: tb/tb_ofm_pkt_fifo.sv
// tb_ofm_pkt_fifo - self-checking bench for ofm_pkt_fifo (64-beat data store).
// Table-driven directed vectors, hand sequences for full / ctrl-full / reset,
// and a randomized packet stream checked against a queue-based model.
`timescale 1ns/1ps
module tb_ofm_pkt_fifo;
   localparam int DWIDTH = 64;
   localparam int CWIDTH = 64;
   localparam int DL     = 6;
   localparam int CL     = 4;
   localparam int DDEPTH = 1 << DL;
   localparam int CDEPTH = 1 << CL;
   localparam int AFT    = DDEPTH - 16;
   localparam int W      = DWIDTH + DWIDTH/8 + 1;

   typedef logic [W-1:0]      beat_t;
   typedef logic [CWIDTH-1:0] cw_t;

   typedef struct {
      logic  wr;  beat_t wd;  logic cwr; cw_t cd; logic ab; logic drd; logic crd;
      logic  ede; beat_t erd; logic ece; cw_t ecr;
   } vec_t;

   logic mm2s_clk    = 1'b0;
   logic mm2s_resetn = 1'b0;

   ofm_pkt_fifo_if #(.DWIDTH(DWIDTH), .CWIDTH(CWIDTH)) bus ();
`ifdef OFM_PKT_FIFO_STATS_EN
   logic [31:0] pkt_cnt, drop_cnt;
`endif

   ofm_pkt_fifo #(
      .DWIDTH(DWIDTH), .CWIDTH(CWIDTH), .DDEPTH_LOG2(DL), .CDEPTH_LOG2(CL), .AFULL_THRESH(AFT)
   ) dut (
      .mm2s_clk    (mm2s_clk),
      .mm2s_resetn (mm2s_resetn),
      .bus         (bus)
`ifdef OFM_PKT_FIFO_STATS_EN
      ,
      .pkt_cnt     (pkt_cnt),
      .drop_cnt    (drop_cnt)
`endif
   );

   always #5 mm2s_clk = ~mm2s_clk;

   int n_vec = 0;
   int n_bad = 0;

   // reference model: committed beats, uncommitted beats, committed control words
   beat_t       mq_c[$];
   beat_t       mq_s[$];
   cw_t         mc[$];
   bit          m_bad;
   int unsigned m_pkt, m_drop;
   int          rem, pkts_done;
   bit          pend;
   vec_t        tbl[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic beat_t bt(input int idx, input bit last);
      logic [63:0] d;
      d = 64'h1000 + 64'(idx);
      return {last, 8'hFF, d};
   endfunction

   function automatic vec_t mkv(input logic wr, input beat_t wd, input logic cwr, input cw_t cd,
                                input logic ab, input logic drd, input logic crd,
                                input logic ede, input beat_t erd, input logic ece, input cw_t ecr);
      vec_t v;
      v.wr = wr; v.wd = wd; v.cwr = cwr; v.cd = cd; v.ab = ab; v.drd = drd; v.crd = crd;
      v.ede = ede; v.erd = erd; v.ece = ece; v.ecr = ecr;
      return v;
   endfunction

   task automatic drive(input logic wr, input beat_t wd, input logic cwr, input cw_t cd,
                        input logic ab, input logic drd, input logic crd);
      bus.data_fifo_wren   = wr;
      bus.data_fifo_wdata  = wd;
      bus.ctrl_fifo_wren   = cwr;
      bus.ctrl_fifo_wdata  = cd;
      bus.data_fifo_wabort = ab;
      bus.data_fifo_rden   = drd;
      bus.ctrl_fifo_rden   = crd;
   endtask

   task automatic tick();
      @(posedge mm2s_clk);
      @(negedge mm2s_clk);
   endtask

   // One randomized cycle: compare flags, score reads, pick writes, advance the model.
   task automatic rstep(input bit allow_wr, input int rd_pct);
      bit    full_m, cfull_m, bad_hit, wr, cwr, ab, drd, crd;
      beat_t wd;
      cw_t   cd;
      int    occ;
      occ     = mq_c.size() + mq_s.size();
      full_m  = (occ == DDEPTH);
      cfull_m = (mc.size() == CDEPTH);
      check("r_full", bus.data_fifo_full, full_m);
      check("r_afull", bus.data_fifo_afull, occ >= AFT);
      check("r_cafull", bus.ctrl_fifo_afull, mc.size() >= CDEPTH - 2);
      drd = ($urandom_range(0, 99) < rd_pct);
      crd = ($urandom_range(0, 99) < rd_pct);
      if (drd && !bus.data_fifo_empty) begin
         check("r_dvisible", mq_c.size() > 0, 1);
         if (mq_c.size() > 0) check("r_data", bus.data_fifo_rdata, mq_c.pop_front());
      end
      if (crd && !bus.ctrl_fifo_empty) begin
         check("r_cvisible", mc.size() > 0, 1);
         if (mc.size() > 0) check("r_ctrl", bus.ctrl_fifo_rdata, mc.pop_front());
      end
      wr = 0; cwr = 0; ab = 0; wd = '0; cd = '0;
      if (allow_wr) begin
         if (rem == 0 && !pend && $urandom_range(0, 3) != 0) rem = $urandom_range(1, 40);
         if (rem > 0) begin
            if ($urandom_range(0, 99) < 3) begin
               ab = 1;
            end else if ($urandom_range(0, 99) < 75) begin
               rem--;
               wr = 1;
               wd = {rem == 0, 8'($urandom), $urandom, $urandom};
               if (rem == 0) begin
                  if ($urandom_range(0, 1) == 1) cwr = 1;
                  else pend = 1;
               end
            end
         end else if (pend && $urandom_range(0, 1) == 1) begin
            cwr = 1;
         end
         if (cwr && $urandom_range(0, 19) == 0) ab = 1;
         if (cwr) cd = {$urandom, $urandom};
         if (ab || cwr) begin
            rem = 0;
            pend = 0;
            pkts_done++;
         end
      end
      bad_hit = wr && full_m;
      if (wr && !full_m) mq_s.push_back(wd);
      if (ab || (cwr && (m_bad || bad_hit || cfull_m))) begin
         mq_s.delete();
         m_bad = 0;
         m_drop++;
      end else if (cwr) begin
         foreach (mq_s[i]) mq_c.push_back(mq_s[i]);
         mq_s.delete();
         mc.push_back(cd);
         m_pkt++;
      end else if (bad_hit) begin
         m_bad = 1;
      end
      drive(wr, wd, cwr, cd, ab, drd, crd);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(0, '0, 0, '0, 0, 0, 0);
      repeat (3) @(negedge mm2s_clk);
      check("rst_dempty", bus.data_fifo_empty, 1);
      check("rst_cempty", bus.ctrl_fifo_empty, 1);
      check("rst_full", bus.data_fifo_full, 0);
      check("rst_afull", bus.data_fifo_afull, 0);
      check("rst_cafull", bus.ctrl_fifo_afull, 0);
      check("rst_rdata", bus.data_fifo_rdata, 0);
      check("rst_crdata", bus.ctrl_fifo_rdata, 0);
      mm2s_resetn = 1'b1;
      tick();

      // ---- directed table: commit/read latency, abort, abort+commit, empty reads
      tbl.push_back(mkv(1, bt(0, 0), 0, 0, 0, 0, 0,      1, '0, 1, 0));
      tbl.push_back(mkv(1, bt(1, 0), 0, 0, 0, 0, 0,      1, '0, 1, 0));
      tbl.push_back(mkv(1, bt(2, 0), 0, 0, 0, 0, 0,      1, '0, 1, 0));
      tbl.push_back(mkv(1, bt(3, 1), 1, 64'hA5, 0, 0, 0, 1, '0, 1, 0));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 0, 0,            0, bt(0, 0), 0, 64'hA5));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 1, 0,            0, bt(1, 0), 0, 64'hA5));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 1, 1,            0, bt(2, 0), 1, 0));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 1, 0,            0, bt(3, 1), 1, 0));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 1, 0,            1, '0, 1, 0));
      tbl.push_back(mkv(1, bt(10, 0), 0, 0, 0, 0, 0,     1, '0, 1, 0));
      tbl.push_back(mkv(1, bt(11, 0), 0, 0, 0, 0, 0,     1, '0, 1, 0));
      tbl.push_back(mkv(1, bt(12, 0), 0, 0, 0, 0, 0,     1, '0, 1, 0));
      tbl.push_back(mkv(0, '0, 0, 0, 1, 0, 0,            1, '0, 1, 0));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 0, 0,            1, '0, 1, 0));
      tbl.push_back(mkv(1, bt(20, 0), 0, 0, 0, 0, 0,     1, '0, 1, 0));
      tbl.push_back(mkv(1, bt(21, 1), 1, 64'h5A, 0, 0, 0, 1, '0, 1, 0));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 0, 0,            0, bt(20, 0), 0, 64'h5A));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 1, 1,            0, bt(21, 1), 1, 0));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 1, 0,            1, '0, 1, 0));
      tbl.push_back(mkv(1, bt(30, 1), 1, 64'h77, 1, 0, 0, 1, '0, 1, 0));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 1, 1,            1, '0, 1, 0));
      tbl.push_back(mkv(1, bt(40, 1), 1, 64'h99, 0, 0, 0, 1, '0, 1, 0));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 0, 0,            0, bt(40, 1), 0, 64'h99));
      tbl.push_back(mkv(0, '0, 0, 0, 0, 1, 1,            1, '0, 1, 0));
      foreach (tbl[i]) begin
         drive(tbl[i].wr, tbl[i].wd, tbl[i].cwr, tbl[i].cd, tbl[i].ab, tbl[i].drd, tbl[i].crd);
         tick();
         check($sformatf("tbl%0d_dempty", i), bus.data_fifo_empty, tbl[i].ede);
         check($sformatf("tbl%0d_cempty", i), bus.ctrl_fifo_empty, tbl[i].ece);
         if (!tbl[i].ede) check($sformatf("tbl%0d_rdata", i), bus.data_fifo_rdata, tbl[i].erd);
         if (!tbl[i].ece) check($sformatf("tbl%0d_crdata", i), bus.ctrl_fifo_rdata, tbl[i].ecr);
      end
      drive(0, '0, 0, '0, 0, 0, 0);
`ifdef OFM_PKT_FIFO_STATS_EN
      check("tbl_pkt_cnt", pkt_cnt, 3);
      check("tbl_drop_cnt", drop_cnt, 2);
`endif

      // ---- overflow: DDEPTH beats fill the store, one more sets bad, commit drops
      for (int k = 1; k <= DDEPTH; k++) begin
         drive(1, bt(100 + k, 0), 0, '0, 0, 0, 0);
         tick();
         check($sformatf("fill%0d_full", k), bus.data_fifo_full, k == DDEPTH);
         check($sformatf("fill%0d_afull", k), bus.data_fifo_afull, k >= AFT);
      end
      check("fill_dempty", bus.data_fifo_empty, 1);
      drive(1, bt(200, 1), 0, '0, 0, 0, 0);
      tick();
      check("ovf_full", bus.data_fifo_full, 1);
      drive(0, '0, 1, 64'hDEAD, 0, 0, 0);
      tick();
      check("ovf_commit_full", bus.data_fifo_full, 0);
      check("ovf_commit_afull", bus.data_fifo_afull, 0);
      drive(0, '0, 0, '0, 0, 0, 0);
      tick();
      check("ovf_dempty", bus.data_fifo_empty, 1);
      check("ovf_cempty", bus.ctrl_fifo_empty, 1);
`ifdef OFM_PKT_FIFO_STATS_EN
      check("ovf_drop_cnt", drop_cnt, 3);
`endif

      // ---- control store: afull at CDEPTH-2, commit into a full store is dropped
      for (int k = 1; k <= CDEPTH; k++) begin
         drive(1, bt(300 + k, 1), 1, cw_t'(64'hC000 + 64'(k)), 0, 0, 0);
         tick();
         check($sformatf("cfill%0d_cafull", k), bus.ctrl_fifo_afull, k >= CDEPTH - 2);
      end
      drive(1, bt(399, 1), 1, 64'hBAD, 0, 0, 0);
      tick();
      check("cfull_cafull", bus.ctrl_fifo_afull, 1);
      drive(0, '0, 0, '0, 0, 0, 0);
      tick();
      for (int i = 1; i <= CDEPTH; i++) begin
         check($sformatf("cdrain%0d_cempty", i), bus.ctrl_fifo_empty, 0);
         check($sformatf("cdrain%0d_crdata", i), bus.ctrl_fifo_rdata, 64'hC000 + 64'(i));
         check($sformatf("cdrain%0d_rdata", i), bus.data_fifo_rdata, bt(300 + i, 1));
         drive(0, '0, 0, '0, 0, 1, 1);
         tick();
      end
      drive(0, '0, 0, '0, 0, 0, 0);
      check("cdrain_dempty", bus.data_fifo_empty, 1);
      check("cdrain_cempty", bus.ctrl_fifo_empty, 1);
      check("cdrain_cafull", bus.ctrl_fifo_afull, 0);
`ifdef OFM_PKT_FIFO_STATS_EN
      check("cfull_pkt_cnt", pkt_cnt, 3 + CDEPTH);
      check("cfull_drop_cnt", drop_cnt, 4);
`endif

      // ---- randomized packet stream across pointer wrap
      rem = 0; pend = 0; pkts_done = 0; m_bad = 0;
      m_pkt = 3 + CDEPTH; m_drop = 4;
      for (int c = 0; c < 30000 && pkts_done < 100; c++) rstep(1, ((c / 200) % 2 == 1) ? 85 : 25);
      check("rand_pkts_done", pkts_done >= 100, 1);
      for (int c = 0; c < 400 && (mq_c.size() > 0 || mc.size() > 0 ||
                                  !bus.data_fifo_empty || !bus.ctrl_fifo_empty); c++)
         rstep(0, 100);
      drive(0, '0, 0, '0, 0, 0, 0);
      check("rand_model_data_left", mq_c.size(), 0);
      check("rand_model_ctrl_left", mc.size(), 0);
      check("rand_dempty", bus.data_fifo_empty, 1);
      check("rand_cempty", bus.ctrl_fifo_empty, 1);
`ifdef OFM_PKT_FIFO_STATS_EN
      check("rand_pkt_cnt", pkt_cnt, m_pkt);
      check("rand_drop_cnt", drop_cnt, m_drop);
`endif

      // ---- reset mid-read and mid-packet, then a fresh packet
      drive(1, bt(500, 0), 0, '0, 0, 0, 0);
      tick();
      drive(1, bt(501, 1), 1, 64'h1234, 0, 0, 0);
      tick();
      drive(0, '0, 0, '0, 0, 0, 0);
      tick();
      drive(0, '0, 0, '0, 0, 1, 0);
      tick();
      drive(1, bt(502, 0), 0, '0, 0, 0, 0);
      tick();
      drive(0, '0, 0, '0, 0, 1, 1);
      #2 mm2s_resetn = 1'b0;
      #1;
      check("mid_rst_dempty", bus.data_fifo_empty, 1);
      check("mid_rst_cempty", bus.ctrl_fifo_empty, 1);
      check("mid_rst_full", bus.data_fifo_full, 0);
      check("mid_rst_afull", bus.data_fifo_afull, 0);
      check("mid_rst_cafull", bus.ctrl_fifo_afull, 0);
      check("mid_rst_rdata", bus.data_fifo_rdata, 0);
      check("mid_rst_crdata", bus.ctrl_fifo_rdata, 0);
`ifdef OFM_PKT_FIFO_STATS_EN
      check("mid_rst_pkt_cnt", pkt_cnt, 0);
      check("mid_rst_drop_cnt", drop_cnt, 0);
`endif
      drive(0, '0, 0, '0, 0, 0, 0);
      @(negedge mm2s_clk);
      mm2s_resetn = 1'b1;
      tick();
      drive(1, bt(600, 0), 0, '0, 0, 0, 0);
      tick();
      drive(1, bt(601, 1), 1, 64'hF00D, 0, 0, 0);
      tick();
      check("post_rst_commit_dempty", bus.data_fifo_empty, 1);
      drive(0, '0, 0, '0, 0, 0, 0);
      tick();
      check("post_rst_dempty", bus.data_fifo_empty, 0);
      check("post_rst_rdata0", bus.data_fifo_rdata, bt(600, 0));
      check("post_rst_crdata", bus.ctrl_fifo_rdata, 64'hF00D);
      drive(0, '0, 0, '0, 0, 1, 1);
      tick();
      check("post_rst_rdata1", bus.data_fifo_rdata, bt(601, 1));
      check("post_rst_cempty", bus.ctrl_fifo_empty, 1);
      drive(0, '0, 0, '0, 0, 1, 0);
      tick();
      check("post_rst_drained", bus.data_fifo_empty, 1);
      drive(0, '0, 0, '0, 0, 0, 0);
`ifdef OFM_PKT_FIFO_STATS_EN
      check("post_rst_pkt_cnt", pkt_cnt, 1);
      check("post_rst_drop_cnt", drop_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
